icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 91 +++++++++
 1 files changed

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module      : icache
// Description : Direct-mapped, one-word-per-frame instruction cache with a
//               single outstanding fill to the memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
module icache #(
    parameter int SETS  = 16,
    parameter int IDX_W = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int TAG_W = 30 - IDX_W;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [0:0]       r_state;
    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [31:0]      r_data [SETS];
    logic [31:0]      r_miss_addr;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0] w_fill_tag;
    logic             w_hit;
    logic             w_fill;
    logic [1:0]       w_unused_offset;

    assign w_idx           = imemaddr[IDX_W+1:2];
    assign w_tag           = imemaddr[31:IDX_W+2];
    assign w_fill_idx      = r_miss_addr[IDX_W+1:2];
    assign w_fill_tag      = r_miss_addr[31:IDX_W+2];
    assign w_unused_offset = imemaddr[1:0];

    assign w_hit  = imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_fill = (r_state == FETCH) & ~iwait;

    // Control state and valid bits are the only reset state; the arrays are not.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_miss_addr <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (imemREN && !w_hit) begin
                        r_state     <= FETCH;
                        r_miss_addr <= {imemaddr[31:2], 2'b00};
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        r_valid[w_fill_idx] <= 1'b1;
                        r_state             <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A reset forces IDLE asynchronously, so w_fill is low and nothing is written.
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= iload;
        end
    end

    assign ihit     = (r_state == IDLE) & w_hit;
    assign imemload = ihit ? r_data[w_idx] : 32'h0;
    assign iREN     = (r_state == FETCH);
    assign iaddr    = iREN ? r_miss_addr : 32'h0;

endmodule
`default_nettype wire
